// File: rtl/serial_add_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_pkg
// Purpose  : Shared types and constants for the bit-serial adder sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package serial_add_pkg;

    localparam int c_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_add_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl_if
// Purpose  : Operand/result handshake bundle; sub exists with SERIAL_ADD_SUB_EN.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_add_ctrl_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum_out;
    logic             cout;
    logic             busy;

    modport master (
`ifdef SERIAL_ADD_SUB_EN
        output sub,
`endif
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, sum_out, cout, busy
    );

    modport slave (
`ifdef SERIAL_ADD_SUB_EN
        input  sub,
`endif
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, sum_out, cout, busy
    );
endinterface
`default_nettype wire

// File: rtl/serial_add_ctrl_bit.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_bit
// Purpose  : One-bit full-adder cell whose carry lives in a local flop.
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_bit
    import serial_add_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic load,
    input  logic cin_init,
    input  logic a,
    input  logic b,
    output logic s,
    output logic carry
);

    logic r_carry;

    // load wins over en so a fresh operation never inherits a stale carry
    always_ff @(posedge clk) begin
        if (reset) begin
            r_carry <= 1'b0;
        end else if (load) begin
            r_carry <= cin_init;
        end else if (en) begin
            r_carry <= maj3(a, b, r_carry);
        end
    end

    assign s     = a ^ b ^ r_carry;
    assign carry = r_carry;

endmodule
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl
// Purpose  : Parallel-in/parallel-out sequencer around a bit-serial adder.
//            Define SERIAL_ADD_SUB_EN to add the sub (A-B) operation.
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
)(
    input  logic                 clk,
    input  logic                 reset,
    serial_add_ctrl_if.slave     bus
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_sum_sr;
    logic [c_CNT_W-1:0] r_bit_cnt;

    logic w_in_ready;
    logic w_out_valid;
    logic w_busy;
    logic w_accept;
    logic w_sub;
    logic w_s;
    logic w_carry;

`ifdef SERIAL_ADD_SUB_EN
    assign w_sub = bus.sub;
`else
    assign w_sub = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Handshake outputs depend on the state register only.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_busy = 1'b1;
                if (r_bit_cnt == c_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_accept = w_in_ready & bus.in_valid;

    // Subtraction is A + ~B + 1: B is inverted here, the +1 is the carry-in.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_sr    <= '0;
            r_b_sr    <= '0;
            r_sum_sr  <= '0;
            r_bit_cnt <= '0;
        end else if (w_accept) begin
            r_a_sr    <= bus.a_in;
            r_b_sr    <= w_sub ? ~bus.b_in : bus.b_in;
            r_bit_cnt <= '0;
        end else if (w_busy) begin
            r_a_sr   <= r_a_sr >> 1;
            r_b_sr   <= r_b_sr >> 1;
            r_sum_sr <= {w_s, r_sum_sr[WIDTH-1:1]};
            if (r_bit_cnt != c_LAST) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    serial_add_bit u_bit (
        .clk      (clk),
        .reset    (reset),
        .en       (w_busy),
        .load     (w_accept),
        .cin_init (w_sub),
        .a        (r_a_sr[0]),
        .b        (r_b_sr[0]),
        .s        (w_s),
        .carry    (w_carry)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.sum_out   = r_sum_sr;
    assign bus.cout      = w_carry;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_ctrl
// Purpose  : Self-checking bench for serial_add_ctrl (honours SERIAL_ADD_SUB_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;
    import serial_add_pkg::*;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sub;
        logic [WIDTH-1:0] sum;
        logic             cout;
        int               hold;
        bit               noise;
    } vec_t;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on WIDTH+1 bits.
    function automatic logic [WIDTH:0] ref_result(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic sub);
        int unsigned ua, ub, r;
        ua = a;
        ub = b;
        if (sub) r = ua + ((2**WIDTH - 1) - ub) + 1;
        else     r = ua + ub;
        return (WIDTH+1)'(r);
    endfunction

    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic sub, input logic [WIDTH-1:0] exp_sum,
                         input logic exp_cout, input int hold, input bit noise,
                         input string name);
        int n;
        int low;
        bit stable;
        logic [WIDTH-1:0] held;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick;
            n++;
        end
        check({name, "_ready_pre"}, 64'(bus.in_ready), 64'd1);
        bus.a_in = a;
        bus.b_in = b;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub = sub;
`endif
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        tick;
        bus.in_valid = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub = ~sub;
`endif
        bus.b_in = ~b;
        check({name, "_busy"}, 64'(bus.busy), 64'd1);
        low = 0;
        n   = 0;
        while (!bus.out_valid && n < 4*WIDTH) begin
            if (!bus.in_ready) low++;
            if (noise) begin
                bus.in_valid = (n >= 1 && n <= 3);
                bus.a_in     = 8'hAA;
            end
            tick;
            n++;
        end
        bus.in_valid = 1'b0;
        check({name, "_latency"}, 64'(n), 64'(WIDTH));
        check({name, "_sum"},  64'(bus.sum_out), 64'(exp_sum));
        check({name, "_cout"}, 64'(bus.cout), 64'(exp_cout));
        check({name, "_busy_done"}, 64'(bus.busy), 64'd0);
        held   = bus.sum_out;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (!bus.in_ready) low++;
            tick;
            if (!bus.out_valid || bus.in_ready || bus.sum_out !== held ||
                bus.cout !== exp_cout) stable = 1'b0;
        end
        if (hold > 0) check({name, "_hold_stable"}, 64'(stable), 64'd1);
        bus.out_ready = 1'b1;
        if (!bus.in_ready) low++;
        tick;
        check({name, "_idle_after"}, {62'd0, bus.in_ready, bus.out_valid}, 64'b10);
        check({name, "_ready_low"}, 64'(low), 64'(WIDTH + 1 + hold));
    endtask

    vec_t vq[$];

    initial begin
        logic [WIDTH:0]   r;
        logic [WIDTH-1:0] ra, rb;
        logic             rs;
        bit               seen;

        vq.push_back('{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0, 1'b0});
        vq.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, 1'b0});
        vq.push_back('{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 5, 1'b0});
        vq.push_back('{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 0, 1'b1});
        vq.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1, 1'b0});
        vq.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 0, 1'b0});
`ifdef SERIAL_ADD_SUB_EN
        vq.push_back('{8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 0, 1'b0});
        vq.push_back('{8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, 0, 1'b0});
        vq.push_back('{8'h33, 8'h33, 1'b1, 8'h00, 1'b1, 2, 1'b0});
`endif

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.out_ready = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub = 1'b0;
`endif
        tick;
        tick;
        check("reset_state", {59'd0, bus.in_ready, bus.out_valid, bus.busy,
              bus.cout, 1'b0}, {59'd0, 5'b10000});
        check("reset_sum", 64'(bus.sum_out), 64'd0);
        reset = 1'b0;
        tick;

        for (int i = 0; i < vq.size(); i++) begin
            do_op(vq[i].a, vq[i].b, vq[i].sub, vq[i].sum, vq[i].cout,
                  vq[i].hold, vq[i].noise, $sformatf("vec%0d", i));
        end

        // Reset while bit_cnt == 3 discards the operation.
        bus.a_in     = 8'h5A;
        bus.b_in     = 8'h3C;
        bus.in_valid = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        repeat (3) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("midreset_state", {59'd0, bus.in_ready, bus.out_valid, bus.busy,
              bus.cout, 1'b0}, {59'd0, 5'b10000});
        check("midreset_sum", 64'(bus.sum_out), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 2*WIDTH; i++) begin
            if (bus.out_valid) seen = 1'b1;
            tick;
        end
        check("midreset_no_result", 64'(seen), 64'd0);
        do_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 0, 1'b0, "post_reset");

        for (int i = 0; i < 40; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
`ifdef SERIAL_ADD_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            r = ref_result(ra, rb, rs);
            do_op(ra, rb, rs, r[WIDTH-1:0], r[WIDTH], int'($urandom_range(0, 2)),
                  1'b0, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
